// File: rtl/i8080_bus_ctrl.sv
// i8080 system-bus controller: status latch and cycle decode, programmable
// wait-state insertion, and edge-triggered interrupts answered with RST n.
module i8080_bus_ctrl #(
  parameter int XLEN      = 8,
  parameter int ADDR_W    = 16,
  parameter int MEM_WAIT  = 0,
  parameter int IO_WAIT   = 1,
  parameter int INTA_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic              dbin,
  input  logic              write_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   data_in,
  output logic [XLEN-1:0]   data_out,
  output logic              data_oe,
  output logic              ready,
  output logic              cpu_int,
  input  logic              irq,
  input  logic [2:0]        irq_vec,
  output logic              mem_en,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [7:0]        io_port,
  output logic              io_rd,
  output logic              io_wr,
  output logic              halted,
  output logic              m1
);

  localparam int B_INTA = 0;
  localparam int B_HLTA = 3;
  localparam int B_OUT  = 4;
  localparam int B_M1   = 5;
  localparam int B_INP  = 6;

  logic [XLEN-1:0] status;
  logic [3:0]      wait_cnt;
  logic            int_pending;
  logic            irq_q;
  logic [2:0]      vec_q;
  logic [2:0]      vec_ack;
  logic            irq_edge;
  logic            ack_sync;
  logic            io_cyc;

  function automatic logic [3:0] wait_load(input logic [XLEN-1:0] st);
    if (st[B_INTA])                 return 4'(INTA_WAIT);
    else if (st[B_INP] | st[B_OUT]) return 4'(IO_WAIT);
    else                            return 4'(MEM_WAIT);
  endfunction

  function automatic logic [3:0] sat_dec(input logic [3:0] c);
    return (c == 4'd0) ? 4'd0 : c - 4'd1;
  endfunction

  assign irq_edge = irq & ~irq_q;
  assign ack_sync = sync & data_in[B_INTA];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status   <= '0;
      wait_cnt <= 4'd0;
    end else if (sync) begin
      status   <= data_in;
      wait_cnt <= wait_load(data_in);
    end else begin
      wait_cnt <= sat_dec(wait_cnt);
    end
  end

  // A new irq edge beats the acknowledge clear; vec_ack snapshots the old vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q       <= 1'b0;
      int_pending <= 1'b0;
      vec_q       <= 3'd0;
      vec_ack     <= 3'd0;
    end else begin
      irq_q <= irq;
      if (ack_sync)
        vec_ack <= vec_q;
      if (irq_edge) begin
        int_pending <= 1'b1;
        vec_q       <= irq_vec;
      end else if (ack_sync) begin
        int_pending <= 1'b0;
      end
    end
  end

  assign io_cyc   = status[B_INP] | status[B_OUT];
  assign mem_en   = ~io_cyc & ~status[B_INTA];
  assign mem_oe   = mem_en & dbin;
  assign mem_we   = mem_en & ~write_n;
  assign io_rd    = status[B_INP] & dbin;
  assign io_wr    = status[B_OUT] & ~write_n;
  assign io_port  = addr[7:0];
  assign halted   = status[B_HLTA];
  assign m1       = status[B_M1];
  assign ready    = (wait_cnt == 4'd0);
  assign cpu_int  = int_pending;
  assign data_oe  = status[B_INTA] & dbin;
  assign data_out = data_oe ? XLEN'({2'b11, vec_ack, 3'b111}) : '0;

  logic unused_bits;
  assign unused_bits = &{1'b0, addr[ADDR_W-1:8], status[2:1], status[XLEN-1:7]};

endmodule
